mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 2: cycles each access is held on the MMU port, legal range 1..15.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 32), if_rdata (out, 32) and if_ack (out, 1): instruction-fetch port.
REQ-006 SHALL have ports mem_rd (in, 1), mem_wr (in, 1), mem_addr (in, 32), mem_wdata (in, 32) and mem_byte (in, 1): data port request.
REQ-007 SHALL have ports mem_rdata (out, 32) and mem_ack (out, 1): data port response.
REQ-008 SHALL have port stall, output, 1 bit: pipeline hold.
REQ-009 SHALL have MMU-side ports mmu_read (out, 1), mmu_write (out, 1), mmu_addr (out, 32), mmu_wdata (out, 32), mmu_bytemode (out, 1) and mmu_rdata (in, 32).

Function
REQ-010 SHALL implement FSM states IDLE, DATA, FETCH and TURN.
REQ-011 In IDLE, SHALL go to DATA if mem_rd|mem_wr, else FETCH if if_req, else stay; data has fixed priority over fetch.
REQ-012 On leaving IDLE, SHALL latch addr, wdata, byte and op; during the access, mmu_* SHALL come only from latches, so upstream changes are ignored.
REQ-013 If mem_rd and mem_wr are both high, SHALL perform a write.
REQ-014 In DATA/FETCH, SHALL drive mmu_read or mmu_write high for exactly ACC_CYCLES consecutive cycles, with mmu_addr, mmu_wdata and mmu_bytemode stable throughout.
REQ-015 Fetches SHALL use mmu_bytemode=0; mmu_wdata SHALL be 0 on reads.
REQ-016 On the last access cycle, SHALL capture mmu_rdata into if_rdata or mem_rdata; a write SHALL leave mem_rdata unchanged.
REQ-017 Acks: the matching ack SHALL be registered, one-cycle, asserted in the cycle after the last access cycle; request at cycle 0 gives ack at cycle ACC_CYCLES+1.
REQ-018 The response data register SHALL hold its value until the next capture.
REQ-019 In IDLE, SHALL ignore a port's request during the cycle that port's ack is high, preventing re-issue.
REQ-020 stall SHALL equal (if_req & ~if_ack) | ((mem_rd|mem_wr) & ~mem_ack), combinationally.
REQ-021 In IDLE and TURN, SHALL drive mmu_read=mmu_write=0.
REQ-022 The access counter SHALL be 4 bits and clear on every state entry; no wrap occurs within the legal range.

Reset
REQ-023 On rst_n low, SHALL immediately enter IDLE and drive mmu_read=mmu_write=0, both acks 0, and all data, addr and counter registers 0, including mid-access.
REQ-024 An access interrupted by reset SHALL NOT be resumed or acked.

Configuration
REQ-025 With MEM_ARB_TURNAROUND_EN defined, DATA/FETCH SHALL exit to TURN, one idle cycle, then IDLE; the ack SHALL be asserted in the TURN cycle.
REQ-026 Without MEM_ARB_TURNAROUND_EN, DATA/FETCH SHALL exit directly to IDLE, TURN SHALL be unreachable, and back-to-back accesses SHALL be separated by one IDLE cycle only.

Structure
REQ-027 State encodings and the ACC_CYCLES default SHALL reside in shared package mem_arb_pkg.
REQ-028 SHALL contain no sub-module: FSM, counter and latches SHALL be in a single module.

Verification
REQ-029 Bench SHALL cover: ACC_CYCLES=2, if_req with if_addr=0x80000000 and mmu_rdata=0x3C08DEAD -> mmu_read high 2 cycles, if_ack at cycle 3, if_rdata=0x3C08DEAD.
REQ-030 Bench SHALL cover: mem_wr with mem_addr=0x80400004, mem_wdata=0x000000A5, mem_byte=1 -> mmu_write 2 cycles, mmu_bytemode=1, mem_rdata unchanged, mem_ack once.
REQ-031 Bench SHALL cover: if_req and mem_rd raised in the same cycle -> DATA served first, then FETCH; stall high until if_ack; each ack pulses once.
REQ-032 Bench SHALL cover: rst_n pulled low during the 2nd access cycle -> mmu_read=0 within that cycle, no ack, FSM IDLE after release.
REQ-033 Bench SHALL cover: with MEM_ARB_TURNAROUND_EN, two back-to-back reads -> exactly one cycle of mmu_read=mmu_write=0 in TURN plus one in IDLE between them; without it -> one idle cycle.
REQ-034 Bench SHALL cover: mem_rd=mem_wr=1 -> mmu_write asserted and mmu_read never asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and the default number of cycles an access is held on the MMU port.
package mem_arb_pkg;

  localparam int ACC_CYCLES_DEFAULT = 2;
  localparam int CNT_W              = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one MMU port, data first.
// Optional MEM_ARB_TURNAROUND_EN inserts a TURN cycle after every access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_byte,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stall,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic        mmu_bytemode,
  input  logic [31:0] mmu_rdata
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_CYCLES - 1);

  // Handshake: a port's request is held until its one-cycle ack; a request
  // seen in IDLE while that same port's ack is high is the old one and ignored.

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             byte_q, byte_d;
  logic             wr_q, wr_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             mem_ack_q, mem_ack_d;

  logic data_req;
  logic fetch_req;
  logic last_cycle;

  assign data_req   = (mem_rd | mem_wr) & ~mem_ack_q;
  assign fetch_req  = if_req & ~if_ack_q;
  assign last_cycle = (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_d      = byte_q;
    wr_d        = wr_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (data_req) begin
          state_d = ST_DATA;
          addr_d  = mem_addr;
          wr_d    = mem_wr;
          wdata_d = mem_wr ? mem_wdata : 32'h0;
          byte_d  = mem_byte;
        end else if (fetch_req) begin
          state_d = ST_FETCH;
          addr_d  = if_addr;
          wr_d    = 1'b0;
          wdata_d = 32'h0;
          byte_d  = 1'b0;
        end
      end
      ST_DATA, ST_FETCH: begin
        if (last_cycle) begin
          cnt_d = '0;
          if (state_q == ST_DATA) begin
            mem_ack_d = 1'b1;
            if (!wr_q) mem_rdata_d = mmu_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mmu_rdata;
          end
`ifdef MEM_ARB_TURNAROUND_EN
          state_d = ST_TURN;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byte_q      <= 1'b0;
      wr_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_q      <= byte_d;
      wr_q        <= wr_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  // MMU strobes decode straight from state so an async reset drops them at once.
  assign mmu_read     = (state_q == ST_FETCH) | ((state_q == ST_DATA) & ~wr_q);
  assign mmu_write    = (state_q == ST_DATA) & wr_q;
  assign mmu_addr     = addr_q;
  assign mmu_wdata    = wdata_q;
  assign mmu_bytemode = byte_q;

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign stall     = (if_req & ~if_ack_q) | ((mem_rd | mem_wr) & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// accesses scored against a transaction-level model of the MMU port.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ACC = ACC_CYCLES_DEFAULT;
`ifdef MEM_ARB_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif
  localparam int TW = 72;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_byte;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        mmu_read;
  logic        mmu_write;
  logic [31:0] mmu_addr;
  logic [31:0] mmu_wdata;
  logic        mmu_bytemode;
  logic [31:0] mmu_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_if  = '0;
  logic [31:0] exp_mem = '0;

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$];

  mem_arbiter #(.ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte(mem_byte), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_bytemode(mmu_bytemode), .mmu_rdata(mmu_rdata)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- MMU-port monitor ----------------
  logic        in_txn = 1'b0;
  logic        m_rd, m_wr, m_bm, m_un;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_len;
  int          idle_run = 0;
  int          last_gap = 0;
  int          if_ack_cnt = 0;
  int          mem_ack_cnt = 0;

  function automatic logic [TW-1:0] pack(input logic rd, input logic wr, input logic bm,
                                          input logic [31:0] a, input logic [31:0] wd,
                                          input logic [3:0] len, input logic un);
    return {rd, wr, bm, a, wd, len, un};
  endfunction

  function automatic logic [TW-1:0] pop_obs();
    if (obs_q.size() == 0) return '1;
    return obs_q.pop_front();
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mmu_read | mmu_write) begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          m_rd     = mmu_read;
          m_wr     = mmu_write;
          m_bm     = mmu_bytemode;
          m_addr   = mmu_addr;
          m_wd     = mmu_wdata;
          m_len    = 4'd1;
          m_un     = 1'b0;
          last_gap = idle_run;
          idle_run = 0;
        end else begin
          if (m_len != 4'hF) m_len = m_len + 4'd1;
          m_rd = m_rd | mmu_read;
          m_wr = m_wr | mmu_write;
          if (mmu_addr != m_addr || mmu_wdata != m_wd || mmu_bytemode != m_bm) m_un = 1'b1;
        end
      end else begin
        if (in_txn) begin
          obs_q.push_back(pack(m_rd, m_wr, m_bm, m_addr, m_wd, m_len, m_un));
          in_txn = 1'b0;
        end
        idle_run++;
      end
      if (if_ack)  if_ack_cnt++;
      if (mem_ack) mem_ack_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic drive_access(input bit is_fetch, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input bit bm, input logic [31:0] rval, output int lat);
    int c0;
    @(negedge clk);
    mmu_rdata = rval;
    if (is_fetch) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_rd    = rd;
      mem_wr    = wr;
      mem_addr  = addr;
      mem_wdata = wd;
      mem_byte  = bm;
    end
    c0  = cyc;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((is_fetch && if_ack) || (!is_fetch && mem_ack)) begin
        lat = cyc - c0;
        break;
      end
      // upstream keeps moving; the latched access must not follow it
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_byte  = 1'($urandom_range(0, 1));
    end
    if_req = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 1'b1;
    mem_addr = 0; mem_wdata = 0; mem_byte = 0; mmu_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_comb: got %b expected 1", stall); end
    mem_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_if = '0; exp_mem = '0;
    checks++;
    if (mmu_read !== 1'b0 || mmu_write !== 1'b0) begin
      failures++; $display("FAIL reset_mmu_strobes: got rd=%b wr=%b expected 0 0", mmu_read, mmu_write);
    end
    checks++;
    if (if_ack !== 1'b0 || mem_ack !== 1'b0) begin
      failures++; $display("FAIL reset_acks: got if=%b mem=%b expected 0 0", if_ack, mem_ack);
    end
    checks++;
    if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got if=%h mem=%h expected 0", if_rdata, mem_rdata);
    end
    checks++;
    if (mmu_addr !== 32'h0 || mmu_wdata !== 32'h0 || mmu_bytemode !== 1'b0) begin
      failures++; $display("FAIL reset_mmu_bus: got a=%h wd=%h bm=%b expected 0", mmu_addr, mmu_wdata, mmu_bytemode);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", dut.state_q); end
  endtask

  task automatic test_fetch();
    int lat, ia, ma;
    logic [TW-1:0] got, exp;
    ia = if_ack_cnt; ma = mem_ack_cnt;
    drive_access(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h3C08_DEAD, lat);
    exp_if = 32'h3C08_DEAD;
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'(ACC), 1'b0));
    checks++;
    if (lat != ACC + 1) begin failures++; $display("FAIL fetch_latency: got %0d expected %0d", lat, ACC + 1); end
    checks++;
    if (if_rdata !== exp_if) begin failures++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, exp_if); end
    got = pop_obs(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL fetch_mmu_txn: got %h expected %h", got, exp); end
    repeat (2) @(negedge clk);
    checks++;
    if (if_ack_cnt - ia != 1 || mem_ack_cnt - ma != 0) begin
      failures++; $display("FAIL fetch_ack_pulses: got if=%0d mem=%0d expected 1 0", if_ack_cnt - ia, mem_ack_cnt - ma);
    end
  endtask

  task automatic test_write();
    int lat, ma;
    logic [31:0] rv;
    logic [TW-1:0] got, exp;
    rv = $urandom;
    drive_access(1'b0, 1'b1, 1'b0, 32'h8040_0000, 32'h0, 1'b0, rv, lat);
    exp_mem = rv;
    void'(pop_obs());
    ma = mem_ack_cnt;
    drive_access(1'b0, 1'b0, 1'b1, 32'h8040_0004, 32'h0000_00A5, 1'b1, ~rv, lat);
    exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 32'h8040_0004, 32'h0000_00A5, 4'(ACC), 1'b0));
    checks++;
    if (lat != ACC + 1) begin failures++; $display("FAIL write_latency: got %0d expected %0d", lat, ACC + 1); end
    checks++;
    if (mem_rdata !== exp_mem) begin failures++; $display("FAIL write_rdata_kept: got %h expected %h", mem_rdata, exp_mem); end
    got = pop_obs(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL write_mmu_txn: got %h expected %h", got, exp); end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_ack_cnt - ma != 1) begin failures++; $display("FAIL write_ack_pulses: got %0d expected 1", mem_ack_cnt - ma); end
  endtask

  task automatic test_priority();
    int c0, mem_lat, if_lat, stall_hi, ia, ma;
    logic [31:0] a_if, a_mem, rv1, rv2;
    logic [TW-1:0] got, exp;
    a_if = $urandom; a_mem = $urandom; rv1 = $urandom; rv2 = $urandom;
    ia = if_ack_cnt; ma = mem_ack_cnt;
    @(negedge clk);
    mmu_rdata = rv1;
    mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = a_mem; mem_byte = 1'b0;
    if_req = 1'b1; if_addr = a_if;
    c0 = cyc; mem_lat = -1; if_lat = -1; stall_hi = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (stall) stall_hi++;
      if (mem_ack && mem_lat < 0) begin mem_lat = cyc - c0; mem_rd = 1'b0; mmu_rdata = rv2; end
      if (if_ack && if_lat < 0) begin if_lat = cyc - c0; if_req = 1'b0; end
      if (if_lat >= 0) break;
      @(negedge clk);
    end
    if_req = 1'b0; mem_rd = 1'b0;
    exp_mem = rv1; exp_if = rv2;
    checks++;
    if (mem_lat != ACC + 1) begin failures++; $display("FAIL prio_mem_latency: got %0d expected %0d", mem_lat, ACC + 1); end
    checks++;
    if (if_lat != 2 * (ACC + 1) + TURN) begin
      failures++; $display("FAIL prio_if_latency: got %0d expected %0d", if_lat, 2 * (ACC + 1) + TURN);
    end
    checks++;
    if (stall_hi != 2 * (ACC + 1) + TURN) begin
      failures++; $display("FAIL prio_stall_cycles: got %0d expected %0d", stall_hi, 2 * (ACC + 1) + TURN);
    end
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, a_mem, 32'h0, 4'(ACC), 1'b0));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, a_if, 32'h0, 4'(ACC), 1'b0));
    for (int i = 0; i < 2; i++) begin
      got = pop_obs(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL prio_txn%0d: got %h expected %h", i, got, exp); end
    end
    checks++;
    if (mem_rdata !== exp_mem || if_rdata !== exp_if) begin
      failures++; $display("FAIL prio_rdata: got mem=%h if=%h expected %h %h", mem_rdata, if_rdata, exp_mem, exp_if);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (if_ack_cnt - ia != 1 || mem_ack_cnt - ma != 1) begin
      failures++; $display("FAIL prio_ack_pulses: got if=%0d mem=%0d expected 1 1", if_ack_cnt - ia, mem_ack_cnt - ma);
    end
  endtask

  task automatic test_back_to_back();
    int c1, if_lat;
    logic [31:0] a1, a2, rv1, rv2;
    logic [TW-1:0] got, exp;
    a1 = $urandom; a2 = $urandom; rv1 = $urandom; rv2 = $urandom;
    @(negedge clk);
    mmu_rdata = rv1; mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = a1; mem_byte = 1'b1;
    c1 = -1; if_lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (c1 < 0 && mem_ack) begin
        mem_rd = 1'b0; if_req = 1'b1; if_addr = a2; mmu_rdata = rv2; c1 = cyc;
      end else if (c1 >= 0 && if_ack) begin
        if_lat = cyc - c1; break;
      end
    end
    if_req = 1'b0; mem_rd = 1'b0;
    exp_mem = rv1; exp_if = rv2;
    checks++;
    if (if_lat != ACC + 1 + TURN) begin
      failures++; $display("FAIL b2b_if_latency: got %0d expected %0d", if_lat, ACC + 1 + TURN);
    end
    checks++;
    if (last_gap != 1 + TURN) begin failures++; $display("FAIL b2b_idle_gap: got %0d expected %0d", last_gap, 1 + TURN); end
    exp_q.push_back(pack(1'b1, 1'b0, 1'b1, a1, 32'h0, 4'(ACC), 1'b0));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, a2, 32'h0, 4'(ACC), 1'b0));
    for (int i = 0; i < 2; i++) begin
      got = pop_obs(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_txn%0d: got %h expected %h", i, got, exp); end
    end
    checks++;
    if (mem_rdata !== exp_mem || if_rdata !== exp_if) begin
      failures++; $display("FAIL b2b_rdata: got mem=%h if=%h expected %h %h", mem_rdata, if_rdata, exp_mem, exp_if);
    end
  endtask

  task automatic test_rd_wr_both();
    int lat;
    logic [31:0] a, wd;
    logic [TW-1:0] got, exp;
    a = $urandom; wd = $urandom;
    drive_access(1'b0, 1'b1, 1'b1, a, wd, 1'b0, $urandom, lat);
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, a, wd, 4'(ACC), 1'b0));
    got = pop_obs(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL rdwr_is_write: got %h expected %h", got, exp); end
    checks++;
    if (mem_rdata !== exp_mem) begin failures++; $display("FAIL rdwr_rdata_kept: got %h expected %h", mem_rdata, exp_mem); end
  endtask

  task automatic test_reset_mid_access();
    int ia;
    logic [31:0] a;
    logic [TW-1:0] got, exp;
    a = $urandom;
    ia = if_ack_cnt;
    @(negedge clk);
    if_req = 1'b1; if_addr = a; mmu_rdata = $urandom;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    exp_if = '0; exp_mem = '0;
    checks++;
    if (mmu_read !== 1'b0) begin failures++; $display("FAIL rstmid_mmu_read: got %b expected 0", mmu_read); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (ACC + 3) @(negedge clk);
    checks++;
    if (if_ack_cnt != ia) begin failures++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", if_ack_cnt - ia); end
    checks++;
    if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rstmid_state: got %0d expected IDLE", dut.state_q); end
    checks++;
    if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin
      failures++; $display("FAIL rstmid_rdata: got if=%h mem=%h expected 0 0", if_rdata, mem_rdata);
    end
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, a, 32'h0, 4'd2, 1'b0));
    got = pop_obs(); exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL rstmid_txn: got %h expected %h", got, exp); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_resumed: got %0d extra accesses expected 0", obs_q.size()); end
  endtask

  task automatic test_random();
    int lat, kind, ia, ma, n_if, n_mem;
    bit fetch, rd, wr, bm;
    logic [31:0] a, wd, rv;
    logic [TW-1:0] got, exp;
    ia = if_ack_cnt; ma = mem_ack_cnt; n_if = 0; n_mem = 0;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      fetch = (kind == 0);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      bm = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; rv = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_access(fetch, rd, wr, a, wd, bm, rv, lat);
      if (fetch) begin
        n_if++; exp_if = rv;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, a, 32'h0, 4'(ACC), 1'b0));
      end else begin
        n_mem++;
        if (!wr) exp_mem = rv;
        exp_q.push_back(pack(!wr, wr, bm, a, wr ? wd : 32'h0, 4'(ACC), 1'b0));
      end
      checks++;
      if (lat != ACC + 1) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, ACC + 1); end
      got = pop_obs(); exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rand%0d_txn: got %h expected %h", i, got, exp); end
      checks++;
      if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin
        failures++; $display("FAIL rand%0d_rdata: got if=%h mem=%h expected %h %h", i, if_rdata, mem_rdata, exp_if, exp_mem);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (if_ack_cnt - ia != n_if || mem_ack_cnt - ma != n_mem) begin
      failures++; $display("FAIL rand_ack_pulses: got if=%0d mem=%0d expected %0d %0d",
                           if_ack_cnt - ia, mem_ack_cnt - ma, n_if, n_mem);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_priority();
    test_back_to_back();
    test_rd_wr_both();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
